alu_req_arbiter: RTL and testbench
==================================

# alu_req_arbiter

Two-requester arbiter and sequencer for the shared W-bit ALU. It accepts complete operation requests from two independent clients over valid/ready handshakes, grants the ALU round-robin, and drives the ALU input bus with both operands valid in a single cycle. It waits the command-dependent ALU latency, captures the ALU result flags and returns them to the granted client over a valid/ready response channel. It sits between the client logic and the ALU input/output pins.

## Interface
- W, 8, operand width; result width is W+2
- LAT, 1, ALU cycles from operand sample to result for non-multiply commands (≥1)
- MUL_LAT, 2, ALU cycles for multiply commands (mode=1, cmd=9 or 10) (≥1)
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- reqN_valid  in  1  request N (N=0,1) presents an operation
- reqN_ready  out  1  request N accepted this cycle
- reqN_opa, reqN_opb  in  W  operands
- reqN_cin, reqN_mode  in  1  carry-in, mode (1=arith, 0=logic)
- reqN_cmd  in  4  ALU command
- rspN_valid  out  1  response for requester N held
- rspN_ready  in  1  requester N consumes response
- rsp_res  out  W+2  captured result, shared by both response channels
- rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e, rsp_err  out  1 each  captured flags
- alu_cen  out  1  ALU clock enable
- alu_opa, alu_opb  out  W  to ALU
- alu_cin, alu_mode  out  1  to ALU
- alu_cmd  out  4  to ALU
- alu_inp_valid  out  2  to ALU
- alu_res  in  W+2  from ALU
- alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_err  in  1 each  from ALU

## Operation
- States: IDLE, ISSUE, WAIT, RESP. One operation in flight at a time.
- Grant pointer `ptr` (1 bit, reset 0) marks the preferred requester.
- IDLE: `gnt` = `ptr` if both requests are valid, else the only valid requester. `reqgnt_ready` = 1, combinational from state and valid. The non-granted ready is 0.
  - On handshake: latch the granted opa/opb/cin/mode/cmd and `gnt`, then go to ISSUE.
  - No request valid: stay in IDLE.
- ISSUE: drive the latched fields with alu_inp_valid=2'b11 for exactly one cycle.
  - Load the wait counter with MUL_LAT if mode=1 and cmd∈{9,10}, else LAT.
  - Go to WAIT.
- WAIT: decrement the counter each cycle.
  - In the cycle where counter==1, capture alu_res and all flags at the closing edge, then go to RESP.
  - WAIT lasts exactly LAT (or MUL_LAT) cycles.
- RESP: `rspgnt_valid` = 1. rsp_* are stable until the handshake.
  - On `rspgnt_ready`: set `ptr` = ~`gnt`, drop rsp valid, go to IDLE.
  - The other rsp valid is always 0.
- alu_inp_valid = 2'b00 in all states except ISSUE. The arbiter never issues a split operand pair (01/10), so the ALU 16-cycle operand-wait error cannot originate here.
- alu_opa/opb/cin/mode/cmd are registered and hold their last value outside ISSUE.
- alu_cen = 0 while rst, then 1 continuously. It never toggles after reset release.
- ALU err (e.g. rotate with opb[7:4]≠0) is passed through unmodified in rsp_err. The arbiter does not filter commands.

## Timing
- Reset values: all ready/valid outputs 0; alu_inp_valid 00; alu_opa/opb/cin/mode/cmd 0; alu_cen 0; rsp_res and all rsp flags 0; state IDLE; ptr 0.
- Latency: handshake in cycle t, then ISSUE in t+1, WAIT in t+2..t+1+L, and rsp valid from t+2+L (L = LAT or MUL_LAT).
- Minimum turnaround is 3+L cycles per operation with rsp_ready tied high. The next accept happens in the cycle after the response handshake.
- The request must be stable only in the handshake cycle. Changes in req fields after acceptance have no effect.
- Simultaneous valid requests: the granted requester follows `ptr`. After each completed response the pointer moves to the other requester.
- A requester dropping valid before ready creates no handshake and consumes no grant.
- Response backpressure: RESP holds indefinitely. No new request is accepted meanwhile (both readys are 0).
- Reset mid-operation (any state): the next cycle is in reset values. The in-flight op is discarded with no response, and ptr returns to 0.

## Test plan
- **Single op:** reset, then req0 with opa=8'h05, opb=8'h03, mode=1, cmd=0, LAT=1. Required: req0_ready=1 in cycle t, alu_inp_valid=11 only in t+1, rsp0_valid in t+3 with rsp_res=8 and rsp1_valid=0 throughout.
- **Contention:** both requests valid continuously, rsp ready high. Required grant order 0,1,0,1, with each alu_inp_valid=11 pulse carrying the matching requester's operands.
- **Multiply latency:** req1 with mode=1, cmd=9, MUL_LAT=2. Required: rsp1_valid appears exactly 4 cycles after the handshake, and the captured res equals the ALU output at the sampling edge.
- **Backpressure:** hold rsp0_ready=0 for 10 cycles with req1 valid. Required: rsp fields stable, req1_ready=0; then req1 is accepted the cycle after rsp0 handshakes.
- **Error passthrough:** mode=0, cmd=12, opb=8'h10. Required: rsp_err=1 copied from the ALU, and alu_inp_valid is never 01 or 10 in the run.
- **Reset in WAIT:** assert rst during WAIT. Required: all outputs at reset values the next cycle, no rspN_valid for the dropped op, and after release a simultaneous request pair grants requester 0 first.

Source files
------------

// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if
// Bundles every signal between the arbiter, its two clients and the shared ALU.
//   req0_*/req1_*  : operation request channels (valid/ready plus operands/command)
//   rsp0_*/rsp1_*  : response handshakes; rsp_res and flags are shared by both
//   alu_*          : ALU input pins (driven by the arbiter) and result pins (from ALU)
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (clients plus ALU)
interface alu_req_arbiter_if #(
  parameter int W = 8
);
  logic         req0_valid, req0_ready;
  logic [W-1:0] req0_opa, req0_opb;
  logic         req0_cin, req0_mode;
  logic [3:0]   req0_cmd;
  logic         req1_valid, req1_ready;
  logic [W-1:0] req1_opa, req1_opb;
  logic         req1_cin, req1_mode;
  logic [3:0]   req1_cmd;

  logic         rsp0_valid, rsp0_ready;
  logic         rsp1_valid, rsp1_ready;
  logic [W+1:0] rsp_res;
  logic         rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e, rsp_err;

  logic         alu_cen;
  logic [W-1:0] alu_opa, alu_opb;
  logic         alu_cin, alu_mode;
  logic [3:0]   alu_cmd;
  logic [1:0]   alu_inp_valid;
  logic [W+1:0] alu_res;
  logic         alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_err;

  modport slave (
    input  req0_valid, req0_opa, req0_opb, req0_cin, req0_mode, req0_cmd,
    input  req1_valid, req1_opa, req1_opb, req1_cin, req1_mode, req1_cmd,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid,
    input  rsp0_ready, rsp1_ready,
    output rsp_res, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e, rsp_err,
    output alu_cen, alu_opa, alu_opb, alu_cin, alu_mode, alu_cmd, alu_inp_valid,
    input  alu_res, alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_err
  );

  modport master (
    output req0_valid, req0_opa, req0_opb, req0_cin, req0_mode, req0_cmd,
    output req1_valid, req1_opa, req1_opb, req1_cin, req1_mode, req1_cmd,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid,
    output rsp0_ready, rsp1_ready,
    input  rsp_res, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e, rsp_err,
    input  alu_cen, alu_opa, alu_opb, alu_cin, alu_mode, alu_cmd, alu_inp_valid,
    output alu_res, alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_err
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
// Round-robin arbiter/sequencer for a shared W-bit ALU with two clients.
// One operation is in flight at a time: accept (IDLE), present both operands
// for one cycle (ISSUE), wait the command latency (WAIT), then hold the captured
// result for the granted client until it is consumed (RESP).
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - alu_req_arbiter_if.slave (request, response and ALU pins)
module alu_req_arbiter #(
  parameter int W       = 8,
  parameter int LAT     = 1,
  parameter int MUL_LAT = 2
) (
  input logic           clk,
  input logic           rst,
  alu_req_arbiter_if.slave bus
);
  localparam int MAX_LAT = (MUL_LAT > LAT) ? MUL_LAT : LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_reg, state_next;
  logic          ptr_reg, gnt_reg;
  logic [CW-1:0] cnt_reg;
  logic [W-1:0]  opa_reg, opb_reg;
  logic          cin_reg, mode_reg;
  logic [3:0]    cmd_reg;
  logic [W+1:0]  res_reg;
  logic          oflow_reg, cout_reg, g_reg, l_reg, e_reg, err_reg;
  logic          cen_reg;

  logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]    inp_valid;
  logic          sel, accept, rsp_hs, is_mul, last_wait;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

  // Pointer only breaks ties; a lone requester is always the one granted.
  assign sel = (&req_valid) ? ptr_reg : req_valid[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      // Ready is withheld during reset so nothing is accepted into a clearing datapath.
      assign req_ready[gi] = (state_reg == IDLE) && !rst && req_valid[gi] && (sel == 1'(gi));
      assign rsp_valid[gi] = (state_reg == RESP) && (gnt_reg == 1'(gi));
    end
  endgenerate

  assign accept    = |req_ready;
  assign rsp_hs    = |(rsp_valid & rsp_ready);
  assign is_mul    = mode_reg && ((cmd_reg == 4'd9) || (cmd_reg == 4'd10));
  assign last_wait = (state_reg == WAIT) && (cnt_reg == CW'(1));

  always_comb begin
    state_next = state_reg;
    inp_valid  = 2'b00;
    case (state_reg)
      IDLE:  if (accept) state_next = ISSUE;
      ISSUE: begin
        inp_valid  = 2'b11;
        state_next = WAIT;
      end
      WAIT:  if (cnt_reg == CW'(1)) state_next = RESP;
      RESP:  if (rsp_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      gnt_reg   <= 1'b0;
      cnt_reg   <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      cin_reg   <= 1'b0;
      mode_reg  <= 1'b0;
      cmd_reg   <= 4'd0;
      res_reg   <= '0;
      oflow_reg <= 1'b0;
      cout_reg  <= 1'b0;
      g_reg     <= 1'b0;
      l_reg     <= 1'b0;
      e_reg     <= 1'b0;
      err_reg   <= 1'b0;
      cen_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cen_reg   <= 1'b1;
      // The ALU operand registers double as the request latch, so they change
      // only on acceptance and hold their value outside ISSUE.
      if (accept) begin
        gnt_reg  <= sel;
        opa_reg  <= sel ? bus.req1_opa  : bus.req0_opa;
        opb_reg  <= sel ? bus.req1_opb  : bus.req0_opb;
        cin_reg  <= sel ? bus.req1_cin  : bus.req0_cin;
        mode_reg <= sel ? bus.req1_mode : bus.req0_mode;
        cmd_reg  <= sel ? bus.req1_cmd  : bus.req0_cmd;
      end
      if (state_reg == ISSUE) begin
        cnt_reg <= is_mul ? CW'(MUL_LAT) : CW'(LAT);
      end else if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg - CW'(1);
      end
      if (last_wait) begin
        res_reg   <= bus.alu_res;
        oflow_reg <= bus.alu_oflow;
        cout_reg  <= bus.alu_cout;
        g_reg     <= bus.alu_g;
        l_reg     <= bus.alu_l;
        e_reg     <= bus.alu_e;
        err_reg   <= bus.alu_err;
      end
      if (rsp_hs) ptr_reg <= ~gnt_reg;
    end
  end

  assign bus.req0_ready    = req_ready[0];
  assign bus.req1_ready    = req_ready[1];
  assign bus.rsp0_valid    = rsp_valid[0];
  assign bus.rsp1_valid    = rsp_valid[1];
  assign bus.rsp_res       = res_reg;
  assign bus.rsp_oflow     = oflow_reg;
  assign bus.rsp_cout      = cout_reg;
  assign bus.rsp_g         = g_reg;
  assign bus.rsp_l         = l_reg;
  assign bus.rsp_e         = e_reg;
  assign bus.rsp_err       = err_reg;
  assign bus.alu_cen       = cen_reg;
  assign bus.alu_opa       = opa_reg;
  assign bus.alu_opb       = opb_reg;
  assign bus.alu_cin       = cin_reg;
  assign bus.alu_mode      = mode_reg;
  assign bus.alu_cmd       = cmd_reg;
  assign bus.alu_inp_valid = inp_valid;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter
// Bench for alu_req_arbiter: a table of single operations, hand sequences for
// contention, backpressure and reset-in-WAIT, then random traffic. A timeline
// model (accept cycle + latency arithmetic) predicts every output each cycle.
module tb_alu_req_arbiter;
  localparam int W       = 8;
  localparam int LAT     = 1;
  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  alu_req_arbiter_if #(.W(W)) bus ();

  alu_req_arbiter #(.W(W), .LAT(LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         idx;
    logic [7:0] opa;
    logic [7:0] opb;
    bit         cin;
    bit         mode;
    logic [3:0] cmd;
    logic [9:0] exp_res;
    bit         exp_err;
    int         exp_lat;
  } vec_t;

  // Result packing: [15]=err [14]=oflow [13]=cout [12]=g [11]=l [10]=e [9:0]=res
  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic mode,
                                         input logic [3:0] cmd);
    logic [9:0]  r;
    logic [15:0] p;
    logic        err;
    p = {8'd0, a} * {8'd0, b};
    if (mode) begin
      if (cmd == 4'd9 || cmd == 4'd10) r = p[9:0];
      else if (cmd == 4'd1)            r = {2'b00, a} - {2'b00, b};
      else                             r = {2'b00, a} + {2'b00, b} + {9'd0, cin};
    end else begin
      r = {2'b00, a ^ b};
    end
    err = !mode && (cmd == 4'd12 || cmd == 4'd13) && (b[7:4] != 4'd0);
    return {err, r[9], r[8], a > b, a < b, a == b, r};
  endfunction

  function automatic int lat_of(input logic mode, input logic [3:0] cmd);
    return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? MUL_LAT : LAT;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ALU stand-in: the correct result appears only in the cycle that is exactly
  // the command latency after the operand sample; every other cycle shows the
  // bitwise inverse, so a capture on the wrong edge is visible.
  logic [15:0] alu_good = 16'h0;
  logic [15:0] alu_drv;
  int          alu_k = 0;
  int          alu_l = 1;

  always @(posedge clk) begin
    if (rst) begin
      alu_k <= 0;
    end else if (bus.alu_inp_valid == 2'b11) begin
      alu_good <= alu_fn(bus.alu_opa, bus.alu_opb, bus.alu_cin, bus.alu_mode, bus.alu_cmd);
      alu_l    <= lat_of(bus.alu_mode, bus.alu_cmd);
      alu_k    <= 1;
    end else if (alu_k != 0 && alu_k < 1000) begin
      alu_k <= alu_k + 1;
    end
  end

  assign alu_drv       = (alu_k == alu_l) ? alu_good : ~alu_good;
  assign bus.alu_res   = alu_drv[9:0];
  assign bus.alu_e     = alu_drv[10];
  assign bus.alu_l     = alu_drv[11];
  assign bus.alu_g     = alu_drv[12];
  assign bus.alu_cout  = alu_drv[13];
  assign bus.alu_oflow = alu_drv[14];
  assign bus.alu_err   = alu_drv[15];

  // Timeline model: an accepted op at cycle t issues at t+1 and responds from t+2+L.
  bit         m_busy = 1'b0;
  bit         m_ptr = 1'b0;
  bit         m_gnt = 1'b0;
  bit         rst_prev = 1'b0;
  bit         split_seen = 1'b0;
  int         m_tacc = 0;
  int         m_lat = 1;
  logic [7:0] m_opa = 8'd0;
  logic [7:0] m_opb = 8'd0;
  logic       m_cin = 1'b0;
  logic       m_mode = 1'b0;
  logic [3:0] m_cmd = 4'd0;

  task automatic model_step();
    bit          v0, v1, eg, idle, issue, in_resp;
    logic [15:0] ef;
    v0      = bus.req0_valid;
    v1      = bus.req1_valid;
    idle    = !m_busy;
    eg      = (v0 && v1) ? m_ptr : v1;
    issue   = m_busy && (cyc == m_tacc + 1);
    in_resp = m_busy && (cyc >= m_tacc + 2 + m_lat);
    if (bus.alu_inp_valid == 2'b01 || bus.alu_inp_valid == 2'b10) split_seen = 1'b1;
    if (cyc > 0) begin
      chk("req0_ready", bus.req0_ready, idle && !rst && v0 && !eg);
      chk("req1_ready", bus.req1_ready, idle && !rst && v1 && eg);
      chk("rsp0_valid", bus.rsp0_valid, in_resp && !m_gnt);
      chk("rsp1_valid", bus.rsp1_valid, in_resp && m_gnt);
      chk("alu_inp_valid", bus.alu_inp_valid, issue ? 2'b11 : 2'b00);
      chk("alu_cen", bus.alu_cen, !rst_prev);
      if (issue) begin
        chk("issue_fields", {bus.alu_opa, bus.alu_opb, bus.alu_cin, bus.alu_mode, bus.alu_cmd},
            {m_opa, m_opb, m_cin, m_mode, m_cmd});
      end
      if (in_resp) begin
        ef = alu_fn(m_opa, m_opb, m_cin, m_mode, m_cmd);
        chk("rsp_res", bus.rsp_res, ef[9:0]);
        chk("rsp_flags", {bus.rsp_err, bus.rsp_oflow, bus.rsp_cout, bus.rsp_g, bus.rsp_l, bus.rsp_e},
            ef[15:10]);
      end
      if (rst_prev) begin
        chk("rst_alu_fields", {bus.alu_opa, bus.alu_opb, bus.alu_cin, bus.alu_mode, bus.alu_cmd}, 0);
        chk("rst_rsp_fields", {bus.rsp_res, bus.rsp_err, bus.rsp_oflow, bus.rsp_cout,
                               bus.rsp_g, bus.rsp_l, bus.rsp_e}, 0);
      end
    end
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = 1'b0;
    end else if (idle && (v0 || v1)) begin
      m_busy = 1'b1;
      m_gnt  = eg;
      m_tacc = cyc;
      m_opa  = eg ? bus.req1_opa  : bus.req0_opa;
      m_opb  = eg ? bus.req1_opb  : bus.req0_opb;
      m_cin  = eg ? bus.req1_cin  : bus.req0_cin;
      m_mode = eg ? bus.req1_mode : bus.req0_mode;
      m_cmd  = eg ? bus.req1_cmd  : bus.req0_cmd;
      m_lat  = lat_of(m_mode, m_cmd);
      $display("cycle %0d: accept req%0d opa=%02h opb=%02h cin=%0d mode=%0d cmd=%0d",
               cyc, eg, m_opa, m_opb, m_cin, m_mode, m_cmd);
    end else if (in_resp && (m_gnt ? bus.rsp1_ready : bus.rsp0_ready)) begin
      m_busy = 1'b0;
      m_ptr  = !m_gnt;
      $display("cycle %0d: response req%0d res=%03h err=%0d", cyc, m_gnt, bus.rsp_res, bus.rsp_err);
    end
    rst_prev = rst;
    cyc++;
  endtask

  always @(negedge clk) model_step();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit idx, input logic v, input logic [7:0] a, input logic [7:0] b,
                           input logic c, input logic m, input logic [3:0] cm);
    if (idx == 1'b0) begin
      bus.req0_valid = v; bus.req0_opa = a; bus.req0_opb = b;
      bus.req0_cin = c; bus.req0_mode = m; bus.req0_cmd = cm;
    end else begin
      bus.req1_valid = v; bus.req1_opa = a; bus.req1_opb = b;
      bus.req1_cin = c; bus.req1_mode = m; bus.req1_cmd = cm;
    end
  endtask

  task automatic drop_req(input bit idx);
    drive_req(idx, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
  endtask

  // Returns in the handshake cycle (mid-cycle) when hs=1.
  task automatic wait_ready(input bit idx, output bit hs);
    hs = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (idx ? bus.req1_ready : bus.req0_ready) begin
        hs = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Called in the cycle after the handshake; n counts cycles since the handshake.
  task automatic wait_rsp(input bit idx, output int lat, output bit got);
    got = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      #1;
      if (idx ? bus.rsp1_valid : bus.rsp0_valid) begin
        lat = n;
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_op(input vec_t v, output int lat, output logic [9:0] res,
                       output logic err, output bit ok);
    bit hs;
    res = '0;
    err = 1'b0;
    lat = 0;
    ok  = 1'b0;
    drive_req(v.idx, 1'b1, v.opa, v.opb, v.cin, v.mode, v.cmd);
    wait_ready(v.idx, hs);
    tick();
    drop_req(v.idx);
    if (hs) begin
      wait_rsp(v.idx, lat, ok);
      res = bus.rsp_res;
      err = bus.rsp_err;
    end
    tick();
  endtask

  initial begin
    vec_t       vecs [6];
    int         lat;
    int         np;
    logic [9:0] res;
    logic [9:0] res0;
    logic       err;
    bit         ok;
    bit         hs;

    vecs[0] = '{1'b0, 8'h05, 8'h03, 1'b0, 1'b1, 4'd0,  10'd8,   1'b0, 3};
    vecs[1] = '{1'b1, 8'd12, 8'd10, 1'b0, 1'b1, 4'd9,  10'd120, 1'b0, 4};
    vecs[2] = '{1'b0, 8'h01, 8'h10, 1'b0, 1'b0, 4'd12, 10'h011, 1'b1, 3};
    vecs[3] = '{1'b1, 8'd3,  8'd4,  1'b0, 1'b1, 4'd10, 10'd12,  1'b0, 4};
    vecs[4] = '{1'b0, 8'hFF, 8'h01, 1'b1, 1'b1, 4'd0,  10'h101, 1'b0, 3};
    vecs[5] = '{1'b1, 8'd9,  8'd4,  1'b0, 1'b1, 4'd1,  10'd5,   1'b0, 3};

    drive_req(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 4'd0);
    drive_req(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 4'd0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("reset_ready", {bus.req1_ready, bus.req0_ready}, 0);
    chk("reset_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
    chk("reset_inp_valid", bus.alu_inp_valid, 0);
    chk("reset_cen", bus.alu_cen, 0);
    chk("reset_rsp_res", bus.rsp_res, 0);
    tick();

    // Table of single operations.
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i], lat, res, err, ok);
      chk("vec_done", ok, 1);
      chk("vec_latency", lat, vecs[i].exp_lat);
      chk("vec_res", res, vecs[i].exp_res);
      chk("vec_err", err, vecs[i].exp_err);
    end

    // Contention: both valid continuously, grants alternate starting at 0.
    drive_req(1'b0, 1'b1, 8'hA0, 8'h11, 1'b0, 1'b1, 4'd0);
    drive_req(1'b1, 1'b1, 8'hB1, 8'h22, 1'b0, 1'b1, 4'd0);
    np = 0;
    for (int n = 0; n < 60 && np < 4; n++) begin
      #1;
      if (bus.alu_inp_valid == 2'b11) begin
        chk("contention_opa", bus.alu_opa, (np % 2 == 0) ? 8'hA0 : 8'hB1);
        np++;
      end
      tick();
    end
    chk("contention_count", np, 4);
    drop_req(1'b0);
    drop_req(1'b1);
    repeat (6) tick();

    // Backpressure: response held, other requester blocked until the handshake.
    bus.rsp0_ready = 1'b0;
    drive_req(1'b0, 1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 4'd0);
    wait_ready(1'b0, hs);
    chk("bp_accept", hs, 1);
    tick();
    drop_req(1'b0);
    wait_rsp(1'b0, lat, ok);
    chk("bp_rsp", ok, 1);
    res0 = bus.rsp_res;
    drive_req(1'b1, 1'b1, 8'h55, 8'h66, 1'b0, 1'b1, 4'd1);
    tick();
    for (int n = 0; n < 10; n++) begin
      #1;
      chk("bp_hold_valid", bus.rsp0_valid, 1);
      chk("bp_hold_res", bus.rsp_res, res0);
      chk("bp_req1_blocked", bus.req1_ready, 0);
      tick();
    end
    bus.rsp0_ready = 1'b1;
    #1;
    chk("bp_req1_in_hs_cycle", bus.req1_ready, 0);
    tick();
    #1;
    chk("bp_req1_after_hs", bus.req1_ready, 1);
    tick();
    drop_req(1'b1);
    wait_rsp(1'b1, lat, ok);
    chk("bp_req1_rsp", ok, 1);
    tick();

    // Leave the pointer at 1, then reset during WAIT of a multiply.
    do_op(vecs[0], lat, res, err, ok);
    chk("pre_reset_op", ok, 1);
    drive_req(1'b0, 1'b1, 8'd7, 8'd6, 1'b0, 1'b1, 4'd9);
    wait_ready(1'b0, hs);
    chk("rstw_accept", hs, 1);
    tick();
    drop_req(1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstw_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
    chk("rstw_inp_valid", bus.alu_inp_valid, 0);
    chk("rstw_cen", bus.alu_cen, 0);
    chk("rstw_opa", bus.alu_opa, 0);
    chk("rstw_rsp_res", bus.rsp_res, 0);
    drive_req(1'b0, 1'b1, 8'h0A, 8'h01, 1'b0, 1'b1, 4'd0);
    drive_req(1'b1, 1'b1, 8'h0B, 8'h02, 1'b0, 1'b1, 4'd0);
    #1;
    chk("rstw_grant_req0", bus.req0_ready, 1);
    chk("rstw_req1_waits", bus.req1_ready, 0);
    tick();
    drop_req(1'b0);
    wait_rsp(1'b0, lat, ok);
    chk("rstw_req0_rsp", ok, 1);
    tick();
    wait_ready(1'b1, hs);
    chk("rstw_req1_accept", hs, 1);
    tick();
    drop_req(1'b1);
    wait_rsp(1'b1, lat, ok);
    chk("rstw_req1_rsp", ok, 1);
    tick();

    // Random traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      drive_req(1'b0, ($urandom % 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
                1'($urandom), 4'($urandom));
      drive_req(1'b1, ($urandom % 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
                1'($urandom), 4'($urandom));
      bus.rsp0_ready = ($urandom % 4) != 0;
      bus.rsp1_ready = ($urandom % 4) != 0;
      tick();
    end
    drop_req(1'b0);
    drop_req(1'b1);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    repeat (10) tick();

    chk("no_split_operand_pair", split_seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
